uart_dev: RTL and testbench

// Memory-mapped UART peripheral on the Bridge device bus, a sibling of the two timers.
// The Bridge drives address, write-enable and write-data, and consumes the read-data and IRQ.
// CPU stores to DATA queue bytes for 8N1 serial transmission; received bytes are held for CPU loads.
// IRQ feeds the CPU external-interrupt vector alongside the timer IRQs.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_dev_if.sv | 13 +
 rtl/uart_tx_fifo.sv | 40 ++++
 rtl/uart_dev.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_dev.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register map, STATUS bit positions, FSM encodings.
// No logic; imported by the UART RTL and its bench.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_VALID     = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_RX_FRAME_ERR = 4;
  localparam int ST_TX_DROP      = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // A programmed divisor of zero runs at one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_dev_if.sv
// Bridge device-bus port of the UART: address/strobes/write data in, read data and IRQ out.
// Read data is combinational; there is no backpressure on this bus.
interface uart_dev_if;
  logic [29:0] Addr;
  logic        WE;
  logic        RE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, RE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, RE, Din, output Dout, IRQ);
endinterface

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO; head is visible combinationally, push/pop take effect on the clock edge.
// Push when full is dropped even if a pop coincides; pop when empty is ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_dev.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serialiser, single-byte RX holding register, level IRQ.
// Register reads are combinational; TX bytes written while the FIFO is full are dropped and flagged.
module uart_dev
  import uart_pkg::*;
#(
  parameter int          TX_DEPTH = 4,
  parameter logic [15:0] DIV_RST  = 16'd868
) (
  input  logic       clk,
  input  logic       reset,
  uart_dev_if.slave  bus,
  output logic       tx,
  input  logic       rx
);
  logic [1:0]  ctrl;
  logic [15:0] div;
  logic [15:0] div_eff;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_overrun, rx_frame_err, tx_drop;
  logic [5:0]  status;

  logic wr_data, wr_status, wr_ctrl, wr_div, rx_pop;
  assign wr_data   = bus.WE && (bus.Addr[1:0] == REG_DATA);
  assign wr_status = bus.WE && (bus.Addr[1:0] == REG_STATUS);
  assign wr_ctrl   = bus.WE && (bus.Addr[1:0] == REG_CTRL);
  assign wr_div    = bus.WE && (bus.Addr[1:0] == REG_DIV);
  assign rx_pop    = bus.RE && (bus.Addr[1:0] == REG_DATA) && rx_valid;
  assign div_eff   = eff_div(div);

  logic unused_bus;
  assign unused_bus = ^{bus.Addr[29:2], bus.Din[31:16]};

  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_head;

  uart_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .din   (bus.Din[7:0]),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_n, tx_empty;

  assign tx_empty = fifo_empty && (tx_state == TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx       <= tx_n;
    end
  end

  // tx is registered from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_n       = tx;
    fifo_pop   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_n = fifo_head;
          tx_cnt_n   = div_eff - 16'd1;
          tx_state_n = TX_START;
          tx_n       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt != 16'd0) tx_cnt_n = tx_cnt - 16'd1;
        else begin
          tx_state_n = TX_DATA;
          tx_idx_n   = 3'd0;
          tx_cnt_n   = div_eff - 16'd1;
          tx_n       = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt != 16'd0) tx_cnt_n = tx_cnt - 16'd1;
        else begin
          tx_cnt_n = div_eff - 16'd1;
          if (tx_idx == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
          end else begin
            tx_idx_n   = tx_idx + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_n       = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != 16'd0) tx_cnt_n = tx_cnt - 16'd1;
        else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_n = fifo_head;
          tx_cnt_n   = div_eff - 16'd1;
          tx_state_n = TX_START;
          tx_n       = 1'b0;
        end else begin
          tx_state_n = TX_IDLE;
          tx_n       = 1'b1;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_n       = 1'b1;
      end
    endcase
  end

  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_half;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_s1, rx_s2, rx_done_ok, rx_done_bad, rx_load;

  assign rx_half = {1'b0, div_eff[15:1]};
  assign rx_load = rx_done_ok && (!rx_valid || rx_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Half-bit wait after the falling edge rejects glitches and centres later samples mid-bit.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_idx_n    = rx_idx;
    rx_shift_n  = rx_shift;
    rx_done_ok  = 1'b0;
    rx_done_bad = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;
        end
      end
      RX_START: begin
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else if (!rx_s2) begin
          rx_state_n = RX_DATA;
          rx_idx_n   = 3'd0;
          rx_cnt_n   = div_eff - 16'd1;
        end else rx_state_n = RX_IDLE;
      end
      RX_DATA: begin
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else begin
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_cnt_n   = div_eff - 16'd1;
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
          else rx_idx_n = rx_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else begin
          rx_state_n  = RX_IDLE;
          rx_done_ok  = rx_s2;
          rx_done_bad = !rx_s2;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Flag sets take priority over a coincident STATUS-write clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl         <= 2'b00;
      div          <= DIV_RST;
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= bus.Din[1:0];
      if (wr_div)  div  <= bus.Din[15:0];
      if (rx_load) rx_data <= rx_shift;
      if (rx_load) rx_valid <= 1'b1;
      else if (rx_pop) rx_valid <= 1'b0;
      if (wr_status) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
        tx_drop      <= 1'b0;
      end
      if (rx_done_ok && rx_valid && !rx_pop) rx_overrun <= 1'b1;
      if (rx_done_bad) rx_frame_err <= 1'b1;
      if (wr_data && fifo_full) tx_drop <= 1'b1;
    end
  end

  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = fifo_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_RX_VALID]     = rx_valid;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_RX_FRAME_ERR] = rx_frame_err;
    status[ST_TX_DROP]      = tx_drop;
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (bus.Addr[1:0])
      REG_DATA:   bus.Dout = {24'd0, rx_data};
      REG_STATUS: bus.Dout = {26'd0, status};
      REG_CTRL:   bus.Dout = {30'd0, ctrl};
      default:    bus.Dout = {16'd0, div};
    endcase
  end

  assign bus.IRQ = (ctrl[0] && tx_empty) || (ctrl[1] && rx_valid);
endmodule

// File: tb/tb_uart_dev.sv
// Randomised self-checking bench for uart_dev: serial waveforms, TX FIFO overflow, RX flags and IRQ
// compared against a byte-level model of the register rules.
module tb_uart_dev;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic rx;

  uart_dev_if bus ();

  uart_dev #(.TX_DEPTH(4), .DIV_RST(16'd868)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mon_div = 4;
  logic [7:0] tx_seen [$];

  logic       m_valid, m_ovr, m_ferr, m_drop;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = {28'd0, a};
    bus.Din  = d;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic pop, output logic [31:0] d);
    bus.Addr = {28'd0, a};
    bus.RE   = pop;
    #1 d = bus.Dout;
    tick();
    bus.RE = 1'b0;
  endtask

  function automatic logic [31:0] exp_status(input logic full, input logic empty);
    return {26'd0, m_drop, m_ferr, m_ovr, m_valid, empty, full};
  endfunction

  function automatic logic [31:0] exp_irq(input logic tx_idle);
    return {31'd0, (m_ctrl[0] & tx_idle) | (m_ctrl[1] & m_valid)};
  endfunction

  function automatic logic [31:0] irq_now();
    return {31'd0, bus.IRQ};
  endfunction

  // Line-level decoder of the serial output, independent of the DUT's internals.
  initial begin : tx_mon
    logic [7:0] b;
    logic ok;
    forever begin
      tick();
      if (reset === 1'b0 && tx === 1'b0) begin
        repeat (mon_div / 2) tick();
        ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_div) tick();
          b[i] = tx;
        end
        repeat (mon_div) tick();
        if (ok && tx === 1'b1) tx_seen.push_back(b);
      end
    end
  end

  task automatic tx_wave_test(input logic [15:0] d, input logic [7:0] b);
    int eff, errs, bit_no;
    logic [7:0] got;
    logic expb;
    logic [31:0] rd;
    eff = (d == 16'd0) ? 1 : int'(d);
    mon_div = eff;
    bus_write(REG_DIV, {16'd0, d});
    bus_write(REG_DATA, {24'd0, b});
    errs = 0;
    got = 8'd0;
    for (int i = 0; i < 10 * eff; i++) begin
      tick();
      bit_no = i / eff;
      if (bit_no == 0) expb = 1'b0;
      else if (bit_no == 9) expb = 1'b1;
      else expb = b[bit_no-1];
      if (tx !== expb) errs++;
      if (bit_no >= 1 && bit_no <= 8 && (i % eff) == eff / 2) got[bit_no-1] = tx;
      if (i == 0) check_val("irq_while_tx_busy", irq_now(), exp_irq(1'b0));
    end
    check_val("tx_wave_errors", errs, 32'd0);
    check_val("tx_byte", {24'd0, got}, {24'd0, b});
    tick();
    bus_read(REG_STATUS, 1'b0, rd);
    check_val("tx_status_after_frame", rd, exp_status(1'b0, 1'b1));
    check_val("irq_tx_empty", irq_now(), exp_irq(1'b1));
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    rx = 1'b0;
    repeat (d) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (d) tick();
    end
    rx = stop;
    repeat (d) tick();
    rx = 1'b1;
    repeat (2 * d) tick();
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_valid = 1'b1;
      m_data  = b;
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0;
    m_data  = 8'd0; m_ctrl = 2'b00;
  endtask

  initial begin : main
    logic [31:0] rd;
    logic [7:0]  burst [5];
    logic [7:0]  b;
    logic        stop;
    int          d;

    reset = 1'b1;
    rx = 1'b1;
    bus.Addr = '0; bus.WE = 1'b0; bus.RE = 1'b0; bus.Din = '0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    check_val("reset_tx", {31'd0, tx}, 32'd1);
    check_val("reset_irq", irq_now(), 32'd0);
    bus_read(REG_STATUS, 1'b0, rd); check_val("reset_status", rd, 32'h2);
    bus_read(REG_DIV, 1'b0, rd);    check_val("reset_div", rd, 32'd868);
    bus_read(REG_CTRL, 1'b0, rd);   check_val("reset_ctrl", rd, 32'd0);

    bus_write(REG_CTRL, 32'd1);
    m_ctrl = 2'b01;
    tx_wave_test(16'd4, 8'hA5);
    for (int k = 0; k < 3; k++)
      tx_wave_test(16'($urandom_range(0, 6)), 8'($urandom));
    bus_write(REG_DIV, 32'd0);
    bus_read(REG_DIV, 1'b0, rd); check_val("div_zero_readback", rd, 32'd0);

    // Burst of six writes into a four-deep FIFO behind a busy serialiser.
    mon_div = 4;
    bus_write(REG_DIV, 32'd4);
    tx_seen.delete();
    for (int k = 0; k < 5; k++) begin
      burst[k] = 8'($urandom);
      bus_write(REG_DATA, {24'd0, burst[k]});
    end
    bus_read(REG_STATUS, 1'b0, rd);
    check_val("burst_full", {31'd0, rd[ST_TX_FULL]}, 32'd1);
    check_val("burst_no_drop_yet", {31'd0, rd[ST_TX_DROP]}, 32'd0);
    bus_write(REG_DATA, {24'd0, 8'($urandom)});
    m_drop = 1'b1;
    bus_read(REG_STATUS, 1'b0, rd);
    check_val("burst_drop_status", rd, exp_status(1'b1, 1'b0));
    for (int t = 0; t < 800 && tx_seen.size() < 5; t++) tick();
    repeat (100) tick();
    check_val("burst_frame_count", tx_seen.size(), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < tx_seen.size())
        check_val($sformatf("burst_byte%0d", k), {24'd0, tx_seen[k]}, {24'd0, burst[k]});
    bus_read(REG_STATUS, 1'b0, rd);
    check_val("burst_done_status", rd, exp_status(1'b0, 1'b1));
    bus_write(REG_STATUS, 32'd0);
    m_drop = 1'b0;
    bus_read(REG_STATUS, 1'b0, rd);
    check_val("drop_cleared", rd, exp_status(1'b0, 1'b1));

    // Receive path.
    bus_write(REG_CTRL, 32'd2);
    m_ctrl = 2'b10;
    bus_write(REG_DIV, 32'd8);
    send_rx(8'h3C, 1'b1, 8); model_frame(8'h3C, 1'b1);
    bus_read(REG_STATUS, 1'b0, rd); check_val("rx_status_3c", rd, exp_status(1'b0, 1'b1));
    check_val("rx_irq_set", irq_now(), exp_irq(1'b1));
    bus_read(REG_DATA, 1'b1, rd);   check_val("rx_data_3c", rd, {24'd0, m_data});
    m_valid = 1'b0;
    check_val("rx_irq_cleared", irq_now(), exp_irq(1'b1));

    b = 8'($urandom);
    send_rx(b, 1'b1, 8); model_frame(b, 1'b1);
    b = 8'($urandom);
    send_rx(b, 1'b1, 8); model_frame(b, 1'b1);
    bus_read(REG_STATUS, 1'b0, rd); check_val("rx_overrun_status", rd, exp_status(1'b0, 1'b1));
    bus_read(REG_DATA, 1'b0, rd);   check_val("rx_first_kept", rd, {24'd0, m_data});
    bus_write(REG_STATUS, 32'd0);
    m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0;
    bus_read(REG_STATUS, 1'b0, rd); check_val("rx_overrun_cleared", rd, exp_status(1'b0, 1'b1));
    bus_read(REG_DATA, 1'b1, rd);   check_val("rx_pop_kept", rd, {24'd0, m_data});
    m_valid = 1'b0;

    rx = 1'b0; tick(); tick(); rx = 1'b1;
    repeat (24) tick();
    bus_read(REG_STATUS, 1'b0, rd); check_val("rx_glitch_rejected", rd, exp_status(1'b0, 1'b1));

    b = 8'($urandom);
    send_rx(b, 1'b0, 8); model_frame(b, 1'b0);
    bus_read(REG_STATUS, 1'b0, rd); check_val("rx_frame_err", rd, exp_status(1'b0, 1'b1));

    for (int k = 0; k < 14; k++) begin
      m_ctrl = 2'($urandom_range(0, 3));
      bus_write(REG_CTRL, {30'd0, m_ctrl});
      case ($urandom_range(0, 3))
        0, 1: begin
          d = 8 + 4 * $urandom_range(0, 2);
          bus_write(REG_DIV, d);
          b = 8'($urandom);
          stop = ($urandom_range(0, 3) != 0);
          send_rx(b, stop, d);
          model_frame(b, stop);
        end
        2: begin
          stop = 1'($urandom_range(0, 1));
          bus_read(REG_DATA, stop, rd);
          check_val($sformatf("rand_data%0d", k), rd, {24'd0, m_data});
          if (stop) m_valid = 1'b0;
        end
        default: begin
          bus_write(REG_STATUS, 32'd0);
          m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0;
        end
      endcase
      bus_read(REG_STATUS, 1'b0, rd);
      check_val($sformatf("rand_status%0d", k), rd, exp_status(1'b0, 1'b1));
      check_val($sformatf("rand_irq%0d", k), irq_now(), exp_irq(1'b1));
    end

    // Reset in the middle of a frame of zeros.
    mon_div = 4;
    bus_write(REG_DIV, 32'd4);
    bus_write(REG_DATA, 32'd0);
    repeat (10) tick();
    check_val("midframe_tx_low", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    tick();
    check_val("midframe_reset_tx", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    model_reset();
    bus_read(REG_STATUS, 1'b0, rd); check_val("midframe_reset_status", rd, 32'h2);
    bus_read(REG_DIV, 1'b0, rd);    check_val("midframe_reset_div", rd, 32'd868);
    repeat (60) tick();
    check_val("midframe_tx_stays_idle", {31'd0, tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
